// File: rtl/flexpad_pkg.sv
// Shared flexpad constants, scan FSM state type and the column-to-nibble mapping
// used by both the LED matrix driver and the keypad scanner.
package flexpad_pkg;

  localparam int unsigned NUM_COLS             = 3;
  localparam int unsigned NUM_ROWS             = 4;
  localparam int unsigned COL_BITS             = 2;
  localparam int unsigned PATTERN_BITS         = NUM_COLS * NUM_ROWS;
  localparam int unsigned DEFAULT_DIVIDER      = 8192;
  localparam int unsigned DEFAULT_COUNTER_BITS = 13;

  typedef enum logic {
    StBlank,
    StDrive
  } scan_state_e;

  // col0 owns the top nibble, col2 the bottom one.
  function automatic logic [NUM_ROWS-1:0] col_nibble(input logic [PATTERN_BITS-1:0] bits,
                                                     input logic [COL_BITS-1:0]     col);
    logic [NUM_ROWS-1:0] nib;
    case (col)
      2'd0:    nib = bits[11:8];
      2'd1:    nib = bits[7:4];
      default: nib = bits[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Pattern/brightness source-to-driver bus with a valid/ready handshake on the pattern word.
interface led_matrix_scan_if #(
  parameter int unsigned PWM_BITS = 4
) ();
  import flexpad_pkg::*;

  logic [PATTERN_BITS-1:0] pattern;
  logic                    pattern_valid;
  logic                    pattern_ready;
  logic [PWM_BITS-1:0]     brightness;

  modport master (
    output pattern,
    output pattern_valid,
    output brightness,
    input  pattern_ready
  );

  modport slave (
    input  pattern,
    input  pattern_valid,
    input  brightness,
    output pattern_ready
  );

endinterface

// File: rtl/scan_timebase.sv
// Column-slot timebase: slot counter, column index and a frame-boundary strobe.
module scan_timebase #(
  parameter int unsigned DIVIDER      = 8192,
  parameter int unsigned COUNTER_BITS = 13,
  parameter int unsigned NUM_COLS     = 3,
  localparam int unsigned ColBits     = $clog2(NUM_COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [COUNTER_BITS-1:0] o_slot_cnt,
  output logic [ColBits-1:0]      o_col_idx,
  output logic                    o_slot_last,
  output logic                    o_boundary
);

  localparam logic [COUNTER_BITS-1:0] SlotLast = COUNTER_BITS'(DIVIDER - 1);
  localparam logic [ColBits-1:0]      ColLast  = ColBits'(NUM_COLS - 1);

  logic [COUNTER_BITS-1:0] r_slot_cnt;
  logic [ColBits-1:0]      r_col_idx;
  logic                    w_slot_last;

  assign w_slot_last = (r_slot_cnt == SlotLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt <= '0;
      r_col_idx  <= '0;
    end else if (w_slot_last) begin
      r_slot_cnt <= '0;
      r_col_idx  <= (r_col_idx == ColLast) ? '0 : r_col_idx + ColBits'(1);
    end else begin
      r_slot_cnt <= r_slot_cnt + COUNTER_BITS'(1);
    end
  end

  assign o_slot_cnt  = r_slot_cnt;
  assign o_col_idx   = r_col_idx;
  assign o_slot_last = w_slot_last;
  assign o_boundary  = (r_col_idx == '0) && (r_slot_cnt == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Multiplexed 3x4 LED matrix driver: blanked column scan, global PWM and a
// double-buffered pattern that only swaps at frame boundaries.
module led_matrix_scan
  import flexpad_pkg::*;
#(
  parameter int unsigned DIVIDER      = DEFAULT_DIVIDER,
  parameter int unsigned COUNTER_BITS = DEFAULT_COUNTER_BITS,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned PWM_BITS     = 4
) (
  input  logic                clk_3p33MHz,
  input  logic                rst,
  led_matrix_scan_if.slave    bus,
  output logic [NUM_COLS-1:0] led_col,
  output logic [NUM_ROWS-1:0] led_row,
  output logic                frame_start
);

  localparam logic [COUNTER_BITS-1:0] BlankLast  = COUNTER_BITS'(BLANK_CYCLES - 1);
  localparam logic [COUNTER_BITS-1:0] DriveFirst = COUNTER_BITS'(BLANK_CYCLES);

  logic [COUNTER_BITS-1:0] w_slot_cnt;
  logic [COL_BITS-1:0]     w_col_idx;
  logic                    w_slot_last;
  logic                    w_boundary;

  scan_timebase #(
    .DIVIDER      (DIVIDER),
    .COUNTER_BITS (COUNTER_BITS),
    .NUM_COLS     (NUM_COLS)
  ) u_timebase (
    .clk         (clk_3p33MHz),
    .rst         (rst),
    .o_slot_cnt  (w_slot_cnt),
    .o_col_idx   (w_col_idx),
    .o_slot_last (w_slot_last),
    .o_boundary  (w_boundary)
  );

  scan_state_e r_state, w_state_d;

  always_ff @(posedge clk_3p33MHz) begin
    if (rst) r_state <= StBlank;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StBlank: if (w_slot_cnt == BlankLast) w_state_d = StDrive;
      StDrive: if (w_slot_last)             w_state_d = StBlank;
      default: w_state_d = StBlank;
    endcase
  end

  // Double buffer: shadow takes the handshake, active only changes on a boundary.
  logic [PATTERN_BITS-1:0] r_shadow;
  logic [PATTERN_BITS-1:0] r_active;
  logic                    r_shadow_full;
  logic [PWM_BITS-1:0]     r_bright_active;
  logic                    w_accept;

  assign bus.pattern_ready = ~r_shadow_full & ~rst;
  assign w_accept          = bus.pattern_valid & bus.pattern_ready;

  always_ff @(posedge clk_3p33MHz) begin
    if (rst) begin
      r_shadow        <= '0;
      r_active        <= '0;
      r_shadow_full   <= 1'b0;
      r_bright_active <= '0;
    end else begin
      if (w_boundary) begin
        r_bright_active <= bus.brightness;
        if (r_shadow_full) begin
          r_active      <= r_shadow;
          r_shadow_full <= 1'b0;
        end
      end
      if (w_accept) begin
        r_shadow      <= bus.pattern;
        r_shadow_full <= 1'b1;
      end
    end
  end

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] w_pwm_eff;
  logic                w_drive;
  logic                w_pwm_on;

  // The first drive cycle sees a cleared count so every slot starts its duty at step 0.
  assign w_drive   = (r_state == StDrive);
  assign w_pwm_eff = (w_drive && (w_slot_cnt == DriveFirst)) ? '0 : r_pwm_cnt;
  assign w_pwm_on  = (w_pwm_eff < r_bright_active);

  always_ff @(posedge clk_3p33MHz) begin
    if (rst)          r_pwm_cnt <= '0;
    else if (w_drive) r_pwm_cnt <= w_pwm_eff + PWM_BITS'(1);
  end

  logic [NUM_COLS-1:0] w_led_col_d;
  logic [NUM_ROWS-1:0] w_led_row_d;

  always_comb begin
    w_led_col_d = '0;
    w_led_row_d = '0;
    if (w_drive) begin
      w_led_col_d = NUM_COLS'(1) << w_col_idx;
      w_led_row_d = col_nibble(r_active, w_col_idx) & {NUM_ROWS{w_pwm_on}};
    end
  end

  always_ff @(posedge clk_3p33MHz) begin
    if (rst) begin
      led_col     <= '0;
      led_row     <= '0;
      frame_start <= 1'b0;
    end else begin
      led_col     <= w_led_col_d;
      led_row     <= w_led_row_d;
      frame_start <= w_boundary;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: a position-based frame model queues the
// expected outputs each cycle; the monitor pops and compares one cycle later.
module tb_led_matrix_scan;

  localparam int Div   = 16;
  localparam int Blank = 4;
  localparam int Frame = 3 * Div;

  typedef struct packed {
    logic [2:0] col;
    logic [3:0] row;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] led_col;
  logic [3:0] led_row;
  logic       frame_start;

  led_matrix_scan_if #(.PWM_BITS(4)) bus ();

  led_matrix_scan #(
    .DIVIDER      (Div),
    .COUNTER_BITS (4),
    .BLANK_CYCLES (Blank),
    .PWM_BITS     (4)
  ) dut (
    .clk_3p33MHz (clk),
    .rst         (rst),
    .bus         (bus),
    .led_col     (led_col),
    .led_row     (led_row),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  // Staged stimulus, applied at the next falling edge.
  logic        s_rst    = 1'b1;
  logic        s_valid  = 1'b0;
  logic [11:0] s_pat    = '0;
  logic [3:0]  s_bright = 4'd15;

  // Reference model state.
  int          m_pos    = 0;
  int          m_bright = 0;
  logic        m_full   = 1'b0;
  logic [11:0] m_shadow = '0;
  logic [11:0] m_active = '0;

  logic [2:0] o_col;
  logic [3:0] o_row;
  logic       o_fs;
  logic       acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    exp_t e;
    logic exp_ready;
    int   slot;
    int   col;
    @(negedge clk);
    o_col = led_col;
    o_row = led_row;
    o_fs  = frame_start;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("led_col", 32'(led_col), 32'(e.col));
      check("led_row", 32'(led_row), 32'(e.row));
      check("frame_start", 32'(frame_start), 32'(e.fs));
    end
    rst               = s_rst;
    bus.pattern_valid = s_valid;
    bus.pattern       = s_pat;
    bus.brightness    = s_bright;
    #1;
    e = '0;
    if (s_rst) begin
      exp_ready = 1'b0;
      m_pos     = 0;
      m_full    = 1'b0;
      m_active  = '0;
      m_bright  = 0;
    end else begin
      exp_ready = ~m_full;
      slot      = m_pos % Div;
      col       = m_pos / Div;
      e.fs      = (m_pos == 0);
      if (slot >= Blank) begin
        e.col = 3'(1 << col);
        if ((slot - Blank) < m_bright) e.row = 4'(m_active >> (4 * (2 - col)));
      end
      if (m_pos == 0) begin
        m_bright = int'(s_bright);
        if (m_full) begin
          m_active = m_shadow;
          m_full   = 1'b0;
        end
      end
      if (s_valid && exp_ready) begin
        m_shadow = s_pat;
        m_full   = 1'b1;
      end
      m_pos = (m_pos + 1) % Frame;
    end
    q.push_back(e);
    check("pattern_ready", 32'(bus.pattern_ready), 32'(exp_ready));
    acc = s_valid & exp_ready;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic offer(input logic [11:0] p);
    int n = 0;
    s_pat   = p;
    s_valid = 1'b1;
    do begin
      cycle();
      n++;
    end while (!acc && n < 200);
    check("accept_timeout", 32'(acc), 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!o_fs && n < 200);
    check("frame_start_timeout", 32'(o_fs), 32'd1);
  endtask

  logic [2:0] dcol[3];
  logic [3:0] drow[3];

  initial begin
    dcol = '{3'b001, 3'b010, 3'b100};
    drow = '{4'b1010, 4'b0101, 4'b1100};

    // Reset held for 5 cycles, then release.
    run(5);
    check("reset_ready", 32'(bus.pattern_ready), 32'd0);
    s_rst = 1'b0;
    run(2);

    // A5C at full brightness; the frame after the swap is checked against fixed values.
    offer(12'hA5C);
    wait_fs();
    for (int j = 1; j < Frame; j++) begin
      cycle();
      if (j % Div == 2) check("blank_col", 32'(o_col), 32'd0);
      if (j % Div == Blank) begin
        check("a5c_col", 32'(o_col), 32'(dcol[j / Div]));
        check("a5c_row", 32'(o_row), 32'(drow[j / Div]));
      end
    end

    // Back-to-back words: the second waits for the shadow to drain.
    offer(12'h111);
    offer(12'h222);
    run(3 * Frame);

    // Brightness sweep.
    s_bright = 4'd4;
    run(2 * Frame);
    s_bright = 4'd0;
    run(2 * Frame);

    // Brightness change mid-frame must wait for the next boundary.
    s_bright = 4'd15;
    run(Frame);
    wait_fs();
    run(Div + 2);
    s_bright = 4'd2;
    run(2 * Frame);

    // Reset during col2 drive.
    wait_fs();
    run(2 * Div + 6);
    s_rst = 1'b1;
    cycle();
    s_rst = 1'b0;
    cycle();
    check("rst_col", 32'(o_col), 32'd0);
    check("rst_row", 32'(o_row), 32'd0);
    run(Frame + 10);

    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("final_col", 32'(led_col), 32'(e.col));
      check("final_row", 32'(led_row), 32'(e.row));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
